cnn_mac_acc: RTL
================

# cnn_mac_acc

Streaming unsigned accumulator that sits directly downstream of the CNN 11×9-bit unsigned product multiplier. It consumes a run of `len` 20-bit products over a valid/ready handshake. It sums them into a saturating accumulator and presents one result word per run on a second valid/ready interface, ready for the bias/activation stage.

## Interface
- `IN_W`, 20, product width; matches the multiplier output.
- `ACC_W`, 24, accumulator/result width; must be ≥ `IN_W`.
- `CNT_W`, 10, width of the run-length counter; max run 2^CNT_W−1.

- `ap_clk`  in  1  single clock; all state on rising edge.
- `ap_rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a run; sampled only in IDLE.
- `len`  in  CNT_W  number of products in the run; latched on accepted `start`.
- `busy`  out  1  high in ACC and HOLD.
- `in_data`  in  IN_W  unsigned product from multiplier.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  high exactly when state is ACC.
- `out_data`  out  ACC_W  saturated sum.
- `out_valid`  out  1  result valid; high exactly when state is HOLD.
- `out_ready`  in  1  downstream accepts result.
- `out_ovf`  out  1  sticky: at least one saturation occurred in the current run; valid with `out_valid`.

## Operation
- States: IDLE, ACC, HOLD. Reset → IDLE.
- In IDLE, when `start`=1:
  - latch `len`, clear `acc`, `cnt` and `ovf`;
  - if `len`≠0, go to ACC;
  - if `len`=0, go straight to HOLD with `out_data`=0 and `out_ovf`=0.
- In ACC, `in_ready`=1. Each beat with `in_valid`&&`in_ready`:
  - `acc` ← sat(`acc` + zero-extended `in_data`); `cnt` ← `cnt`+1;
  - on the beat where `cnt` = `len`−1, go to HOLD.
  - Cycles with `in_valid`=0 are bubbles: no state change.
- Saturation: form an (ACC_W+1)-bit sum. If the carry bit is set, load all-ones into `acc` and set `ovf`. Once saturated, `acc` stays all-ones for the rest of the run.
- In HOLD, `out_valid`=1 and `out_data`/`out_ovf` are stable. On `out_ready`=1, go to IDLE.
- `start` outside IDLE is ignored. `len` is not sampled outside IDLE.
- `ap_rst_n` low at any time, including mid-run or in HOLD: the run is aborted with no result emitted, and all state clears asynchronously.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `busy`=0, `out_data`=0, `out_ovf`=0.
- `in_ready`, `out_valid` and `busy` are decoded from the state register only. There is no combinational path from `in_valid`, `out_ready` or `start`.
- Throughput: 1 product/cycle in ACC.
- `start` accepted in cycle T:
  - `busy`=1 and `in_ready`=1 from T+1;
  - for `len`=0, `out_valid`=1 from T+1.
- Last beat accepted in cycle T: `in_ready`=0 and `out_valid`=1 from T+1, with the final sum already on `out_data`.
- Run latency with no bubbles: `len`+1 cycles from `start` to `out_valid`.
- Result handshake in cycle T: `out_valid`=0 at T+1. The earliest next `start` is accepted at T+1.
- `out_data` holds its last value in IDLE until the next `start` clears it.

## Structure
- Shared package `cnn_mac_pkg` holds:
  - the state enum (IDLE/ACC/HOLD);
  - the default `IN_W`/`ACC_W`/`CNT_W` constants;
  - an `ACC_MAX` all-ones constant.
- One sub-module, `cnn_sat_add`: a combinational unsigned ACC_W + IN_W saturating adder with an overflow flag. The top level holds the FSM, counter and registers.

## Test plan
- Basic run: `len`=4, products 1,2,3,4 back-to-back → `out_valid` 5 cycles after `start`, `out_data`=10, `out_ovf`=0.
- Bubbles and backpressure: `len`=3, products 0x00100, 0x00200, 0x00300 with idle cycles between them; hold `out_ready`=0 for 5 cycles → `out_data`=0x600 held stable; `out_valid` drops the cycle after `out_ready`=1.
- Saturation: `len`=17, each product 0xFFFFF → `out_data`=0xFFFFFF, `out_ovf`=1. Next run with `len`=1 and product 5 → `out_data`=5, `out_ovf`=0.
- Zero-length run: `len`=0 → `out_valid` the cycle after `start`, `out_data`=0, `in_ready` never asserted.
- Ignored start: `start` pulsed in ACC with `len`=2, then later in HOLD → the run completes with its original `len`=4 count and no extra run occurs.
- Reset mid-run: assert `ap_rst_n`=0 after 2 of 4 beats → all outputs 0 immediately. After release, a new `len`=2 run of 7,8 → `out_data`=15.

Source files
------------

// File: rtl/cnn_mac_pkg.sv
// Shared types and default widths for the CNN product accumulator slice.
package cnn_mac_pkg;

  localparam int unsigned DEF_IN_W  = 20;
  localparam int unsigned DEF_ACC_W = 24;
  localparam int unsigned DEF_CNT_W = 10;

  localparam logic [DEF_ACC_W-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/cnn_sat_add.sv
// Combinational unsigned saturating adder: ACC_W accumulator plus zero-extended IN_W operand.
module cnn_sat_add #(
  parameter int unsigned IN_W  = 20,
  parameter int unsigned ACC_W = 24
) (
  input  logic [ACC_W-1:0] a,
  input  logic [IN_W-1:0]  b,
  output logic [ACC_W-1:0] y,
  output logic             ovf
);

  logic [ACC_W:0] sum;

  always_comb begin
    sum = {1'b0, a} + (ACC_W+1)'(b);
    ovf = sum[ACC_W];
    y   = ovf ? '1 : sum[ACC_W-1:0];
  end

endmodule

// File: rtl/cnn_mac_acc.sv
// Streaming saturating accumulator: sums a run of len products and presents one result word.
module cnn_mac_acc
  import cnn_mac_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned ACC_W = DEF_ACC_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ovf
);

  state_t           state;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic             ovf;
  logic             add_ovf;

  cnn_sat_add #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_sat_add (
    .a   (acc),
    .b   (in_data),
    .y   (acc_next),
    .ovf (add_ovf)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
      len_q <= '0;
      cnt   <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= len;
            cnt   <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
            state <= (len == '0) ? HOLD : ACC;
          end
        end
        ACC: begin
          if (in_valid) begin
            acc <= acc_next;
            ovf <= ovf | add_ovf;
            cnt <= cnt + CNT_W'(1);
            if (cnt == len_q - CNT_W'(1)) state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode the state register only; no input-to-output paths.
  always_comb begin
    in_ready  = (state == ACC);
    out_valid = (state == HOLD);
    busy      = (state == ACC) || (state == HOLD);
    out_data  = acc;
    out_ovf   = ovf;
  end

endmodule
